// File: rtl/uart_rx.sv
// Purpose : UART deframer (start, 8 data LSB-first, optional parity, stop) presenting bytes with a one-cycle strobe.
// Latency : 2 sync + CLKS_PER_BIT/2 + N*CLKS_PER_BIT + 1 cycles from rx fall to valid (N = 10 with parity, 9 without).
// Backpressure: none; the consumer must take each byte on the valid pulse. Optional parity: define UART_RX_PARITY_EN.
module uart_rx #(
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       parity_sel,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q;
    logic          rx_meta_q;
    logic          rxs_q;
    logic          rxs_prev_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          frame_err_q;
    logic          busy_q;
    logic          cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // Two-flop synchronizer plus one extra stage for falling-edge detection; idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic psel_q;
    logic pbit_q;
    logic parity_err_q;
`else
    // Parity selection has no meaning in the 8N1 build.
    logic unused_parity_sel;
    assign unused_parity_sel = parity_sel;
`endif

    // Frame FSM: bit timing, shifting, and registered output update at the stop-bit sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            psel_q       <= 1'b0;
            pbit_q       <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (!cnt_zero) begin
                cnt_q <= cnt_q - CW'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (rxs_prev_q && !rxs_q) begin
                        cnt_q   <= HALF_M1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_zero) begin
                        if (!rxs_q) begin
`ifdef UART_RX_PARITY_EN
                            psel_q    <= parity_sel;
`endif
                            busy_q    <= 1'b1;
                            bit_idx_q <= 3'd0;
                            cnt_q     <= FULL_M1;
                            state_q   <= S_DATA;
                        end else begin
                            // Line was high again at mid start bit: treat as a glitch.
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (cnt_zero) begin
                        shift_q   <= {rxs_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        cnt_q     <= FULL_M1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_zero) begin
                        pbit_q  <= rxs_q;
                        cnt_q   <= FULL_M1;
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_zero) begin
                        data_q      <= shift_q;
                        frame_err_q <= ~rxs_q;
                        valid_q     <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        // Even: error on odd total ones; odd: error on even total ones.
                        parity_err_q <= (^shift_q) ^ pbit_q ^ psel_q;
`endif
                        if (rxs_q) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // Line held low past the stop bit: wait for it to release before rearming.
                    if (rxs_q) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames, glitch, break and mid-frame reset, then randomized frames.
// Expected bytes, error flags and valid timing are queued by the driver and compared by a separate monitor.
// Works for both builds; define UART_RX_PARITY_EN to exercise parity.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB  = 10;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = 9;
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       parity_sel = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         t;
    } exp_t;
    exp_t sb[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .parity_sel (parity_sel),
        .data       (data),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // Advance n clock edges and land 1ns after the last one.
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every valid pulse must match the oldest queued expectation.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (valid) begin
            check("valid_single_cycle", int'(prev_valid), 0);
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("data", int'(data), int'(e.d));
                check("parity_err", int'(parity_err), int'(e.pe));
                check("frame_err", int'(frame_err), int'(e.fe));
                check("valid_latency", cyc, e.t);
            end
        end
        prev_valid <= valid;
    end

    // Drive one frame; the expectation is derived from the line content alone.
    task automatic send_frame(input logic [7:0] d, input logic psel, input logic pbit,
                              input logic stop, input int gap_bits, input logic chg_psel);
        exp_t e;
        int ones;
        check("busy_idle_before_frame", int'(busy), 0);
        parity_sel = psel;
        rx = 1'b0;
        ones = $countones(d) + (PAR ? int'(pbit) : 0);
        e.d  = d;
        e.pe = PAR ? (((ones % 2) == 1) != psel) : 1'b0;
        e.fe = ~stop;
        e.t  = cyc + 2 + H + NB * CPB + 1;
        sb.push_back(e);
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == 2 && chg_psel) parity_sel = 1'($urandom);
            if (i == 4) check("busy_mid_frame", int'(busy), 1);
            hold(CPB);
        end
        if (PAR) begin
            rx = pbit;
            hold(CPB);
        end
        rx = stop;
        hold(CPB);
        if (!stop) begin
            // Line stays low for two more bit times, then releases.
            hold(2 * CPB);
            check("busy_in_break", int'(busy), 1);
            rx = 1'b1;
            hold(CPB);
        end
        rx = 1'b1;
        if (gap_bits > 0) begin
            check("busy_after_frame", int'(busy), 0);
            hold(gap_bits * CPB);
        end
    endtask

    initial begin
        int seen;
        logic [7:0] d;
        logic ps;
        rst = 1'b0;
        rx  = 1'b1;
        hold(3);
        check("rst_data", int'(data), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_parity_err", int'(parity_err), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b1;
        hold(4);

        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        send_frame(8'h80, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1, 1'b1);

        // Short low glitch must not start a frame.
        rx = 1'b0;
        hold(CPB / 4);
        rx = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * CPB; i++) begin
            if (busy) seen = 1;
            hold(1);
        end
        check("glitch_busy", seen, 0);

        // Break: stop bit low and line held low for three bit times.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1, 1'b0);

        // Reset during data bit 4 discards the partial byte.
        d = 8'hF0;
        parity_sel = 1'b0;
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            hold(CPB);
        end
        rx = d[4];
        hold(H);
        check("busy_before_abort", int'(busy), 1);
        rst = 1'b0;
        rx  = 1'b1;
        #1;
        check("abort_data", int'(data), 0);
        check("abort_valid", int'(valid), 0);
        check("abort_parity_err", int'(parity_err), 0);
        check("abort_frame_err", int'(frame_err), 0);
        check("abort_busy", int'(busy), 0);
        hold(3);
        rst = 1'b1;
        hold(CPB);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1, 1'b0);

        // Randomized frames: data, parity choice, occasional bad parity/stop, back-to-back gaps.
        for (int n = 0; n < 30; n++) begin
            logic pb;
            d  = 8'($urandom);
            ps = 1'($urandom);
            pb = 1'(($countones(d) % 2)) ^ ps ^ ($urandom_range(0, 7) == 0);
            send_frame(d, ps, pb, $urandom_range(0, 7) != 0,
                       $urandom_range(0, 2), 1'($urandom));
        end

        for (int i = 0; i < 4 * NB * CPB && sb.size() != 0; i++) hold(1);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that deframes asynchronous UART traffic on `rx` and presents each received byte to `calc` as a parallel word with a one-cycle strobe. It is the direct upstream stage of `calc`'s command logic and the counterpart of `uart_tx`: it decodes the same frame format and parity selection that `uart_tx` produces. Parity is optional at compile time, and parity and framing errors are reported alongside each byte.

## Interface
- `CLKS_PER_BIT`, default 2604: clock cycles per bit (50 MHz / 19200 baud); must be ≥ 8.
- `clk`  in  1  system clock, 50 MHz, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `parity_sel`  in  1  0 = even parity, 1 = odd parity; same encoding as `uart_tx` `Parity_sel`.
- `data`  out  8  last received byte.
- `valid`  out  1  one-cycle pulse when a frame completes.
- `parity_err`  out  1  parity mismatch on the last frame.
- `frame_err`  out  1  stop bit sampled low on the last frame.
- `busy`  out  1  high from validated start bit until return to IDLE.

## Operation
- Frame format: start bit (0), 8 data bits LSB first, parity bit (only with the macro), one stop bit (1).
- `rx` passes through a 2-flop synchronizer that resets to 1. All logic below uses the synchronized value `rxs`.
- States:
  - IDLE: on `rxs` falling (previous sample 1, current 0), load bit counter with `CLKS_PER_BIT/2 - 1` and go to START.
  - START: at counter expiry, re-sample `rxs`.
    - If 0: latch `parity_sel` into `psel_q`, assert `busy`, clear bit index, reload counter with `CLKS_PER_BIT-1`, go to DATA.
    - If 1: false start; return to IDLE with no outputs changed.
  - DATA: at each expiry, shift `rxs` into the MSB of the shift register (LSB-first reception). After the 8th bit, go to PARITY (macro defined) or STOP.
  - PARITY: at expiry, store the parity bit and go to STOP.
    - Even: error when `^shift ^ pbit == 1`.
    - Odd: error when `^shift ^ pbit == 0`.
  - STOP: at expiry, sample the stop bit.
    - Load `data`, `parity_err`, and `frame_err = ~rxs`; pulse `valid`.
    - If `rxs` is 1, go to IDLE.
    - If `rxs` is 0, go to BREAK.
  - BREAK: wait for `rxs == 1`, then go to IDLE. No new frame is detected while in BREAK.
- `data` and both error flags hold their value until the next `valid`. A byte with a parity or framing error is still delivered.
- Changes on `parity_sel` during a frame have no effect on that frame.
- Reset asserted mid-frame aborts the frame immediately and returns to IDLE; the partial byte is discarded.

## Timing
- Reset values: `data` = 8'h00, `valid` = 0, `parity_err` = 0, `frame_err` = 0, `busy` = 0, state IDLE, synchronizer = 1.
- Sampling point: mid-bit, at `CLKS_PER_BIT/2 + k*CLKS_PER_BIT` cycles after the synchronized falling edge.
- Latency from the `rx` falling edge to `valid`:
  - 2 cycles (synchronizer) + `CLKS_PER_BIT/2 + N*CLKS_PER_BIT` + 1 register cycle.
  - N = 10 with parity, 9 without.
- `valid` is high for exactly one cycle, in the same cycle `data` and the error flags update.
- `busy` rises in the cycle after start validation and falls in the cycle the FSM enters IDLE.
- Back-to-back frames: a start edge arriving half a bit after the stop-bit sample is detected. No idle gap is required.

## Configuration
- `UART_RX_PARITY_EN` defined: 11-bit frame (start, 8 data, parity, stop); PARITY state is present; `parity_sel` is honoured.
- `UART_RX_PARITY_EN` undefined: 10-bit frame (8N1); PARITY state is absent; `parity_sel` is ignored; `parity_err` is tied to 0.

## Test plan
- Macro on, `parity_sel`=0; drive 0x55 with even parity bit 0 → `data`=8'h55, one `valid` pulse, `parity_err`=0, `frame_err`=0.
- Macro on, `parity_sel`=1; drive 0x00 with parity bit 1, then 0x80 with parity bit 0 back-to-back → two `valid` pulses, `data` 8'h00 then 8'h80, no errors.
- Macro on, `parity_sel`=0; drive 0x01 with parity bit 0 → `data`=8'h01, `parity_err`=1. Next correct frame → `parity_err`=0.
- Low glitch on `rx` lasting `CLKS_PER_BIT/4` cycles → no `valid`, `busy` stays 0.
- Frame 0xA5 with stop bit 0, `rx` held low for 3 bit times → `frame_err`=1 with `valid`; no second `valid` until `rx` returns high and a new frame is sent.
- `rst` pulled low during data bit 4 → all outputs at reset values within the same cycle. The next full frame 0x3C is received correctly.
